// File: rtl/rv_dec_pkg.sv
// Shared types for the RV32I/E(+M) decode stage: op codes, opcode
// constants, immediate formats, occupancy states and the decoded record.
package rv_dec_pkg;

  localparam int OP_W = 6;

  typedef enum logic [OP_W-1:0] {
    OP_ILLEGAL = 6'd0,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND,
    OP_FENCE, OP_ECALL, OP_EBREAK,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  // opcode[6:2] values (opcode[1:0] is always 2'b11 for 32-bit encodings)
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SH
  } imm_fmt_e;

  // Occupancy of the output register + skid register pair
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rd_we;
    logic        rs1_used;
    logic        rs2_used;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

  // Build the 32-bit immediate for a given encoding format
  function automatic logic [31:0] imm_gen(input imm_fmt_e fmt, input logic [31:0] ins);
    logic [31:0] v;
    case (fmt)
      IMM_I:   v = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   v = {ins[31:12], 12'b0};
      IMM_J:   v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      IMM_SH:  v = {27'b0, ins[24:20]};
      default: v = 32'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rv_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// Handshake: a word moves on a rising edge exactly when valid & ready are
// both high; a producer holding valid keeps its payload stable until that
// edge, and ready may depend on nothing the producer drives in the same cycle.
interface rv_decode_stage_if #(parameter int PC_W = 32);
  import rv_dec_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  op_e             out_op;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic            out_rd_we;
  logic            out_rs1_used;
  logic            out_rs2_used;
  logic [31:0]     out_imm;
  logic            out_illegal;

  occ_e            dbg_state;

  // Environment side: fetch producer plus execute consumer
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2,
           out_rd_we, out_rs1_used, out_rs2_used, out_imm, out_illegal, dbg_state
  );

  // Decode stage side
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2,
           out_rd_we, out_rs1_used, out_rs2_used, out_imm, out_illegal, dbg_state
  );

endinterface

// File: rtl/rv_dec_comb.sv
// Purely combinational RV32I/E(+M) instruction decoder.
module rv_dec_comb
  import rv_dec_pkg::*;
#(
  parameter bit RV32E    = 1'b0,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0] i_instr,
  output dec_t        o_dec
);

  logic [4:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  op_e        w_op;
  imm_fmt_e   w_fmt;
  logic       w_use_rd;
  logic       w_use_rs1;
  logic       w_use_rs2;
  logic       w_reg_bad;
  logic       w_illegal;

  assign w_opc = i_instr[6:2];
  assign w_f3  = i_instr[14:12];
  assign w_f7  = i_instr[31:25];

  // Classify the encoding; anything not matched stays OP_ILLEGAL
  always_comb begin
    w_op      = OP_ILLEGAL;
    w_fmt     = IMM_NONE;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (w_opc)
      OPC_LUI:   begin w_op = OP_LUI;   w_fmt = IMM_U; w_use_rd = 1'b1; end
      OPC_AUIPC: begin w_op = OP_AUIPC; w_fmt = IMM_U; w_use_rd = 1'b1; end
      OPC_JAL:   begin w_op = OP_JAL;   w_fmt = IMM_J; w_use_rd = 1'b1; end
      OPC_JALR: begin
        w_fmt = IMM_I; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
        if (w_f3 == 3'b000) w_op = OP_JALR;
      end
      OPC_BRANCH: begin
        w_fmt = IMM_B; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        case (w_f3)
          3'b000:  w_op = OP_BEQ;
          3'b001:  w_op = OP_BNE;
          3'b100:  w_op = OP_BLT;
          3'b101:  w_op = OP_BGE;
          3'b110:  w_op = OP_BLTU;
          3'b111:  w_op = OP_BGEU;
          default: w_op = OP_ILLEGAL;
        endcase
      end
      OPC_LOAD: begin
        w_fmt = IMM_I; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
        case (w_f3)
          3'b000:  w_op = OP_LB;
          3'b001:  w_op = OP_LH;
          3'b010:  w_op = OP_LW;
          3'b100:  w_op = OP_LBU;
          3'b101:  w_op = OP_LHU;
          default: w_op = OP_ILLEGAL;
        endcase
      end
      OPC_STORE: begin
        w_fmt = IMM_S; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        case (w_f3)
          3'b000:  w_op = OP_SB;
          3'b001:  w_op = OP_SH;
          3'b010:  w_op = OP_SW;
          default: w_op = OP_ILLEGAL;
        endcase
      end
      OPC_OP_IMM: begin
        w_fmt = IMM_I; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
        case (w_f3)
          3'b000: w_op = OP_ADDI;
          3'b010: w_op = OP_SLTI;
          3'b011: w_op = OP_SLTIU;
          3'b100: w_op = OP_XORI;
          3'b110: w_op = OP_ORI;
          3'b111: w_op = OP_ANDI;
          3'b001: begin
            w_fmt = IMM_SH;
            if (w_f7 == 7'b0000000) w_op = OP_SLLI;
          end
          default: begin
            w_fmt = IMM_SH;
            if (w_f7 == 7'b0000000)      w_op = OP_SRLI;
            else if (w_f7 == 7'b0100000) w_op = OP_SRAI;
          end
        endcase
      end
      OPC_OP: begin
        w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        if (w_f7 == 7'b0000000) begin
          case (w_f3)
            3'b000:  w_op = OP_ADD;
            3'b001:  w_op = OP_SLL;
            3'b010:  w_op = OP_SLT;
            3'b011:  w_op = OP_SLTU;
            3'b100:  w_op = OP_XOR;
            3'b101:  w_op = OP_SRL;
            3'b110:  w_op = OP_OR;
            default: w_op = OP_AND;
          endcase
        end else if (w_f7 == 7'b0100000) begin
          if (w_f3 == 3'b000)      w_op = OP_SUB;
          else if (w_f3 == 3'b101) w_op = OP_SRA;
        end else if (w_f7 == 7'b0000001 && ENABLE_M) begin
          case (w_f3)
            3'b000:  w_op = OP_MUL;
            3'b001:  w_op = OP_MULH;
            3'b010:  w_op = OP_MULHSU;
            3'b011:  w_op = OP_MULHU;
            3'b100:  w_op = OP_DIV;
            3'b101:  w_op = OP_DIVU;
            3'b110:  w_op = OP_REM;
            default: w_op = OP_REMU;
          endcase
        end
      end
      OPC_MISC_MEM: begin
        if (w_f3 == 3'b000) w_op = OP_FENCE;
      end
      OPC_SYSTEM: begin
        if (i_instr == 32'h0000_0073)      w_op = OP_ECALL;
        else if (i_instr == 32'h0010_0073) w_op = OP_EBREAK;
      end
      default: w_op = OP_ILLEGAL;
    endcase
  end

  // RV32E has only x0..x15: bit 4 of any used register field is illegal
  assign w_reg_bad = RV32E && ((w_use_rd  && i_instr[11]) ||
                               (w_use_rs1 && i_instr[19]) ||
                               (w_use_rs2 && i_instr[24]));

  assign w_illegal = (i_instr[1:0] != 2'b11) || (w_op == OP_ILLEGAL) || w_reg_bad;

  // Assemble the decoded record; illegal words carry only the flag
  always_comb begin
    o_dec = '0;
    if (w_illegal) begin
      o_dec.op      = OP_ILLEGAL;
      o_dec.illegal = 1'b1;
    end else begin
      o_dec.op       = w_op;
      o_dec.rd       = w_use_rd  ? i_instr[11:7]  : 5'd0;
      o_dec.rs1      = w_use_rs1 ? i_instr[19:15] : 5'd0;
      o_dec.rs2      = w_use_rs2 ? i_instr[24:20] : 5'd0;
      o_dec.rd_we    = w_use_rd && (i_instr[11:7] != 5'd0);
      o_dec.rs1_used = w_use_rs1;
      o_dec.rs2_used = w_use_rs2;
      o_dec.imm      = imm_gen(w_fmt, i_instr);
    end
  end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode stage: combinational decoder feeding an output register
// with an optional skid register so in_ready comes straight from a flop.
module rv_decode_stage
  import rv_dec_pkg::*;
#(
  parameter bit RV32E    = 1'b0,
  parameter bit ENABLE_M = 1'b0,
  parameter int SKID     = 1,
  parameter int PC_W     = 32
) (
  input logic          clk,
  input logic          rst_n,
  input logic          flush,
  rv_decode_stage_if.slave bus
);

  dec_t            w_dec;
  occ_e            r_state;
  occ_e            w_next;
  logic            r_in_ready;
  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_in_xfer;
  logic            w_out_xfer;
  logic            w_ld_out_in;
  logic            w_ld_out_skid;
  logic            w_ld_skid;
  logic [PC_W-1:0] r_out_pc;
  logic [PC_W-1:0] r_skid_pc;
  dec_t            r_out_dec;
  dec_t            r_skid_dec;

  rv_dec_comb #(
    .RV32E    (RV32E),
    .ENABLE_M (ENABLE_M)
  ) u_dec_comb (
    .i_instr (bus.in_instr),
    .o_dec   (w_dec)
  );

  assign w_out_valid = (r_state != OCC_EMPTY);
  assign w_in_ready  = (SKID != 0) ? r_in_ready : (!w_out_valid || bus.out_ready);
  assign w_in_xfer   = bus.in_valid && w_in_ready;
  assign w_out_xfer  = w_out_valid && bus.out_ready;

  // Occupancy state and registered in_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= OCC_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != OCC_TWO);
    end
  end

  // Next occupancy from the two transfers; flush empties the stage
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = OCC_EMPTY;
    end else begin
      case (r_state)
        OCC_EMPTY: if (w_in_xfer) w_next = OCC_ONE;
        OCC_ONE: begin
          if (w_in_xfer && !w_out_xfer)      w_next = (SKID != 0) ? OCC_TWO : OCC_ONE;
          else if (!w_in_xfer && w_out_xfer) w_next = OCC_EMPTY;
        end
        OCC_TWO:   if (w_out_xfer) w_next = OCC_ONE;
        default:   w_next = OCC_EMPTY;
      endcase
    end
  end

  // Register load strobes for the current state
  always_comb begin
    w_ld_out_in   = 1'b0;
    w_ld_out_skid = 1'b0;
    w_ld_skid     = 1'b0;
    if (!flush) begin
      w_ld_out_in   = w_in_xfer && ((r_state == OCC_EMPTY) ||
                                    (r_state == OCC_ONE && w_out_xfer));
      w_ld_skid     = w_in_xfer && (r_state == OCC_ONE) && !w_out_xfer;
      w_ld_out_skid = (r_state == OCC_TWO) && w_out_xfer;
    end
  end

  // Output and skid data registers; untouched while execute stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_pc   <= '0;
      r_out_dec  <= '0;
      r_skid_pc  <= '0;
      r_skid_dec <= '0;
    end else begin
      if (w_ld_out_in) begin
        r_out_pc  <= bus.in_pc;
        r_out_dec <= w_dec;
      end else if (w_ld_out_skid) begin
        r_out_pc  <= r_skid_pc;
        r_out_dec <= r_skid_dec;
      end
      if (w_ld_skid) begin
        r_skid_pc  <= bus.in_pc;
        r_skid_dec <= w_dec;
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_pc       = r_out_pc;
  assign bus.out_op       = r_out_dec.op;
  assign bus.out_rd       = r_out_dec.rd;
  assign bus.out_rs1      = r_out_dec.rs1;
  assign bus.out_rs2      = r_out_dec.rs2;
  assign bus.out_rd_we    = r_out_dec.rd_we;
  assign bus.out_rs1_used = r_out_dec.rs1_used;
  assign bus.out_rs2_used = r_out_dec.rs2_used;
  assign bus.out_imm      = r_out_dec.imm;
  assign bus.out_illegal  = r_out_dec.illegal;
  assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: three configurations (base, +M, RV32E)
// driven in lockstep, field checks per vector and an in-order pc scoreboard.
module tb_rv_decode_stage;
  import rv_dec_pkg::*;

  localparam logic [31:0] W_ADDI = 32'hFFF0_0293;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] instr;
    op_e         ob;
    op_e         om;
    op_e         oe;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        we;
    logic        u1;
    logic        u2;
  } vec_t;

  vec_t vecs[14];

  // clock
  always #5 clk = ~clk;

  rv_decode_stage_if #(.PC_W(32)) bus_b ();
  rv_decode_stage_if #(.PC_W(32)) bus_m ();
  rv_decode_stage_if #(.PC_W(32)) bus_e ();

  rv_decode_stage #(.RV32E(1'b0), .ENABLE_M(1'b0), .SKID(1), .PC_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_b));
  rv_decode_stage #(.RV32E(1'b0), .ENABLE_M(1'b1), .SKID(1), .PC_W(32)) dut_m (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_m));
  rv_decode_stage #(.RV32E(1'b1), .ENABLE_M(1'b0), .SKID(1), .PC_W(32)) dut_e (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_e));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Drive one cycle (called at a negedge), score transfers, wait next negedge
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    bus_b.in_valid = v; bus_b.in_instr = ins; bus_b.in_pc = pc; bus_b.out_ready = ordy;
    bus_m.in_valid = v; bus_m.in_instr = ins; bus_m.in_pc = pc; bus_m.out_ready = ordy;
    bus_e.in_valid = v; bus_e.in_instr = ins; bus_e.in_pc = pc; bus_e.out_ready = ordy;
    flush = fl;
    #1;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (bus_b.out_valid && bus_b.out_ready) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("sb_order_pc", bus_b.out_pc, exp_q.pop_front());
      end
      if (bus_b.in_valid && bus_b.in_ready) exp_q.push_back(pc);
    end
    @(negedge clk);
  endtask

  task automatic chk_out(input string who, input op_e eop, input vec_t v, input logic [31:0] epc,
                         input logic vld, input logic [31:0] pc, input op_e op,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm, input logic we, input logic u1, input logic u2,
                         input logic ill);
    bit il;
    il = (eop == OP_ILLEGAL);
    check({who, "_valid"},   32'(vld), 32'd1);
    check({who, "_pc"},      pc, epc);
    check({who, "_op"},      32'(op), 32'(eop));
    check({who, "_illegal"}, 32'(ill), 32'(il));
    check({who, "_rd"},      32'(rd),  il ? 32'd0 : 32'(v.rd));
    check({who, "_rs1"},     32'(rs1), il ? 32'd0 : 32'(v.rs1));
    check({who, "_rs2"},     32'(rs2), il ? 32'd0 : 32'(v.rs2));
    check({who, "_imm"},     imm,      il ? 32'd0 : v.imm);
    check({who, "_rd_we"},   32'(we),  il ? 32'd0 : 32'(v.we));
    check({who, "_rs1_used"}, 32'(u1), il ? 32'd0 : 32'(v.u1));
    check({who, "_rs2_used"}, 32'(u2), il ? 32'd0 : 32'(v.u2));
  endtask

  initial begin
    logic [31:0] pc;
    //            instr          base        +M          RV32E       rd     rs1    rs2    imm            we    u1    u2
    vecs[0]  = '{32'h0020_8463, OP_BEQ,     OP_BEQ,     OP_BEQ,     5'd0,  5'd1,  5'd2,  32'd8,         1'b0, 1'b1, 1'b1};
    vecs[1]  = '{32'hFFF0_0293, OP_ADDI,    OP_ADDI,    OP_ADDI,    5'd5,  5'd0,  5'd0,  32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{32'h1234_5537, OP_LUI,     OP_LUI,     OP_LUI,     5'd10, 5'd0,  5'd0,  32'h1234_5000, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{32'h0231_00B3, OP_ILLEGAL, OP_MUL,     OP_ILLEGAL, 5'd1,  5'd2,  5'd3,  32'd0,         1'b1, 1'b1, 1'b1};
    vecs[4]  = '{32'h0020_8833, OP_ADD,     OP_ADD,     OP_ILLEGAL, 5'd16, 5'd1,  5'd2,  32'd0,         1'b1, 1'b1, 1'b1};
    vecs[5]  = '{32'h0020_87B3, OP_ADD,     OP_ADD,     OP_ADD,     5'd15, 5'd1,  5'd2,  32'd0,         1'b1, 1'b1, 1'b1};
    vecs[6]  = '{32'h0011_2623, OP_SW,      OP_SW,      OP_SW,      5'd0,  5'd2,  5'd1,  32'd12,        1'b0, 1'b1, 1'b1};
    vecs[7]  = '{32'h4031_5093, OP_SRAI,    OP_SRAI,    OP_SRAI,    5'd1,  5'd2,  5'd0,  32'd3,         1'b1, 1'b1, 1'b0};
    vecs[8]  = '{32'h4231_5093, OP_ILLEGAL, OP_ILLEGAL, OP_ILLEGAL, 5'd0,  5'd0,  5'd0,  32'd0,         1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'hFFDF_F0EF, OP_JAL,     OP_JAL,     OP_JAL,     5'd1,  5'd0,  5'd0,  32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{32'h0000_0073, OP_ECALL,   OP_ECALL,   OP_ECALL,   5'd0,  5'd0,  5'd0,  32'd0,         1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h0020_0073, OP_ILLEGAL, OP_ILLEGAL, OP_ILLEGAL, 5'd0,  5'd0,  5'd0,  32'd0,         1'b0, 1'b0, 1'b0};
    vecs[12] = '{32'h0000_0001, OP_ILLEGAL, OP_ILLEGAL, OP_ILLEGAL, 5'd0,  5'd0,  5'd0,  32'd0,         1'b0, 1'b0, 1'b0};
    vecs[13] = '{32'h0000_0013, OP_ADDI,    OP_ADDI,    OP_ADDI,    5'd0,  5'd0,  5'd0,  32'd0,         1'b0, 1'b1, 1'b0};

    bus_b.in_valid = 1'b0; bus_b.in_instr = '0; bus_b.in_pc = '0; bus_b.out_ready = 1'b0;
    bus_m.in_valid = 1'b0; bus_m.in_instr = '0; bus_m.in_pc = '0; bus_m.out_ready = 1'b0;
    bus_e.in_valid = 1'b0; bus_e.in_instr = '0; bus_e.in_pc = '0; bus_e.out_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus_b.out_valid), 32'd0);
    check("rst_out_pc",    bus_b.out_pc, 32'd0);
    check("rst_out_op",    32'(bus_b.out_op), 32'd0);
    check("rst_out_imm",   bus_b.out_imm, 32'd0);
    check("rst_illegal",   32'(bus_b.out_illegal), 32'd0);
    check("rst_state",     32'(bus_b.dbg_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(bus_b.in_ready), 32'd1);

    // directed decode, one per cycle, out_ready held high
    for (int i = 0; i < 14; i++) begin
      pc = 32'h100 + 32'(4 * i);
      check("dec_in_ready", 32'(bus_b.in_ready), 32'd1);
      drive(1'b1, vecs[i].instr, pc, 1'b1, 1'b0);
      chk_out("base", vecs[i].ob, vecs[i], pc, bus_b.out_valid, bus_b.out_pc, bus_b.out_op,
              bus_b.out_rd, bus_b.out_rs1, bus_b.out_rs2, bus_b.out_imm, bus_b.out_rd_we,
              bus_b.out_rs1_used, bus_b.out_rs2_used, bus_b.out_illegal);
      chk_out("m", vecs[i].om, vecs[i], pc, bus_m.out_valid, bus_m.out_pc, bus_m.out_op,
              bus_m.out_rd, bus_m.out_rs1, bus_m.out_rs2, bus_m.out_imm, bus_m.out_rd_we,
              bus_m.out_rs1_used, bus_m.out_rs2_used, bus_m.out_illegal);
      chk_out("e", vecs[i].oe, vecs[i], pc, bus_e.out_valid, bus_e.out_pc, bus_e.out_op,
              bus_e.out_rd, bus_e.out_rs1, bus_e.out_rs2, bus_e.out_imm, bus_e.out_rd_we,
              bus_e.out_rs1_used, bus_e.out_rs2_used, bus_e.out_illegal);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("dec_drained_valid", 32'(bus_b.out_valid), 32'd0);
    check("dec_q_empty", 32'(exp_q.size()), 32'd0);

    // backpressure: three pushes against a stalled consumer, then drain
    drive(1'b1, W_ADDI, 32'h0, 1'b0, 1'b0);
    check("bp_in_ready_1", 32'(bus_b.in_ready), 32'd1);
    check("bp_pc_1", bus_b.out_pc, 32'h0);
    drive(1'b1, W_ADDI, 32'h4, 1'b0, 1'b0);
    check("bp_in_ready_2", 32'(bus_b.in_ready), 32'd0);
    check("bp_state_two", 32'(bus_b.dbg_state), 32'd2);
    check("bp_pc_2", bus_b.out_pc, 32'h0);
    drive(1'b1, W_ADDI, 32'h8, 1'b0, 1'b0);
    check("bp_in_ready_3", 32'(bus_b.in_ready), 32'd0);
    check("bp_pc_stable", bus_b.out_pc, 32'h0);
    check("bp_imm_stable", bus_b.out_imm, 32'hFFFF_FFFF);
    drive(1'b1, W_ADDI, 32'h8, 1'b1, 1'b0);
    check("bp_pc_skid", bus_b.out_pc, 32'h4);
    check("bp_in_ready_4", 32'(bus_b.in_ready), 32'd1);
    drive(1'b1, W_ADDI, 32'h8, 1'b1, 1'b0);
    check("bp_pc_last", bus_b.out_pc, 32'h8);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("bp_drained", 32'(bus_b.out_valid), 32'd0);
    check("bp_q_empty", 32'(exp_q.size()), 32'd0);

    // flush while full with an offered instruction
    drive(1'b1, W_ADDI, 32'h200, 1'b0, 1'b0);
    drive(1'b1, W_ADDI, 32'h204, 1'b0, 1'b0);
    check("fl_state_two", 32'(bus_b.dbg_state), 32'd2);
    drive(1'b1, W_ADDI, 32'h208, 1'b0, 1'b1);
    check("fl_out_valid", 32'(bus_b.out_valid), 32'd0);
    check("fl_in_ready", 32'(bus_b.in_ready), 32'd1);
    check("fl_state", 32'(bus_b.dbg_state), 32'd0);
    drive(1'b1, W_ADDI, 32'h210, 1'b1, 1'b1);
    check("fl_drop_in", 32'(bus_b.out_valid), 32'd0);
    drive(1'b1, W_ADDI, 32'h20C, 1'b1, 1'b0);
    check("fl_next_valid", 32'(bus_b.out_valid), 32'd1);
    check("fl_next_pc", bus_b.out_pc, 32'h20C);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("fl_drained", 32'(bus_b.out_valid), 32'd0);
    check("fl_q_empty", 32'(exp_q.size()), 32'd0);

    // asynchronous reset mid-stream
    drive(1'b1, W_ADDI, 32'h300, 1'b0, 1'b0);
    check("ar_held_valid", 32'(bus_b.out_valid), 32'd1);
    bus_b.in_valid = 1'b0; bus_m.in_valid = 1'b0; bus_e.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(bus_b.out_valid), 32'd0);
    check("ar_out_pc", bus_b.out_pc, 32'd0);
    check("ar_out_op", 32'(bus_b.out_op), 32'd0);
    check("ar_out_imm", bus_b.out_imm, 32'd0);
    check("ar_out_rd", 32'(bus_b.out_rd), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_in_ready", 32'(bus_b.in_ready), 32'd1);
    drive(1'b1, 32'h1234_5537, 32'h304, 1'b1, 1'b0);
    check("ar_first_valid", 32'(bus_b.out_valid), 32'd1);
    check("ar_first_pc", bus_b.out_pc, 32'h304);
    check("ar_first_op", 32'(bus_b.out_op), 32'(OP_LUI));
    check("ar_first_imm", bus_b.out_imm, 32'h1234_5000);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("ar_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered, parametrised RV32I/E(+M) instruction decode stage between fetch and execute.
- Accepts {pc, instruction} with a valid/ready handshake and decodes it to a one-hot-free op code, register indices, a sign-extended 32-bit immediate and legality flags.
- Holds the result in an output register with an optional skid buffer, so fetch sees a fully registered in_ready.
- Supports pipeline flush.

Parameters:
- RV32E, 0: 1 = 16-register base; any rd/rs1/rs2 index with bit 4 set (in a used field) is illegal.
- ENABLE_M, 0: 1 = decode MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0 = these are illegal.
- SKID, 1: 1 = 2-entry (output reg + skid reg), in_ready registered; 0 = single reg, in_ready = !out_valid | out_ready.
- PC_W, 32: width of the pc field carried through.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all held and incoming instructions
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  32  instruction word
- in_pc  in  PC_W  instruction address
- out_valid  out  1  decoded instruction available
- out_ready  in  1  execute accepts
- out_pc  out  PC_W  pc of the decoded instruction
- out_op  out  OP_W  operation code (package enum)
- out_rd, out_rs1, out_rs2  out  5 each  register indices, 0 when the field is unused
- out_rd_we  out  1  writes rd (0 if rd==0 or no destination)
- out_rs1_used, out_rs2_used  out  1 each  source operands read
- out_imm  out  32  sign-extended immediate (I/S/B/U/J), 0 for R-type
- out_illegal  out  1  illegal instruction

Behaviour:
- Reset (async, rst_n=0): out_valid=0; all out_* data fields 0; skid empty; in_ready=1 after release.
- Transfer rules:
  - in-transfer = in_valid & in_ready.
  - out-transfer = out_valid & out_ready.
  - Latency: accepted at edge N, visible on out_* from N (after edge), i.e. 1 cycle.
  - Order is strictly preserved. No loss or duplication under any valid/ready pattern.
- SKID=1 occupancy FSM (EMPTY, ONE, TWO):
  - EMPTY: in-transfer -> ONE.
  - ONE: in-transfer without out-transfer -> TWO (data into skid). Out-transfer without in-transfer -> EMPTY. Both -> ONE (new data into output reg).
  - TWO: out-transfer -> ONE (skid moves to output reg).
  - in_ready = (state != TWO), driven from a register.
- out_* data are stable while out_valid & !out_ready.
- flush: next state EMPTY, out_valid=0. An in-transfer in the same cycle is dropped. Flush takes priority over everything except reset.
- Decode is combinational on in_instr and registered on in-transfer:
  - in_instr[1:0] != 2'b11 -> illegal.
  - Unknown opcode[6:2], funct3 or funct7 (for R-type/shifts) -> illegal.
  - SLLI/SRLI/SRAI with instr[25]=1 -> illegal.
  - FENCE, ECALL, EBREAK decoded; other SYSTEM encodings -> illegal.
- Illegal instruction: out_op=OP_ILLEGAL, out_illegal=1, rd/rs/imm/we/used all 0, out_pc valid. It still flows through the handshake.
- Immediates:
  - I = sext(instr[31:20]).
  - S = sext({[31:25],[11:7]}).
  - B = sext({[31],[7],[30:25],[11:8],0}).
  - U = {[31:12],12'b0}.
  - J = sext({[31],[19:12],[20],[30:21],0}).
  - Shift-immediate ops: imm = {27'b0, instr[24:20]}.

Decomposition:
- Package rv_dec_pkg holds:
  - the op enum: OP_ILLEGAL=0, then LUI, AUIPC, JAL, JALR, 6 branches, 5 loads, 3 stores, 9 OP-IMM, 10 OP, FENCE, ECALL, EBREAK, 8 M ops;
  - OP_W=6;
  - opcode[6:2] constants;
  - the immediate-format enum.
- Sub-module rv_dec_comb is purely combinational (instr -> op, indices, flags, imm), parametrised by RV32E and ENABLE_M. rv_decode_stage wraps it with the handshake/skid logic.

Test Plan:
- Decode directed words, out_ready=1:
  - 0x00208463 -> op=BEQ, rs1=1, rs2=2, imm=8, rd_we=0.
  - 0xFFF00293 -> ADDI, rd=5, rs1=0, imm=0xFFFFFFFF, rd_we=1.
  - 0x12345537 -> LUI, rd=10, imm=0x12345000.
- ENABLE_M=0, 0x023100B3 (mul x1,x2,x3) -> out_illegal=1, op=OP_ILLEGAL, pc passed. ENABLE_M=1 -> op=MUL, rd=1, rs1=2, rs2=3.
- RV32E=1, add x16,x1,x2 (0x00208833) -> illegal. add x15,x1,x2 (0x002087B3) -> legal ADD.
- Backpressure, SKID=1: push pcs 0x0, 0x4, 0x8 with out_ready=0 -> in_ready falls after the 2nd accept. Then out_ready=1 -> pcs emerge 0x0, 0x4, 0x8 in order, none lost.
- Flush in the state-TWO cycle while in_valid=1 -> next cycle out_valid=0, in_ready=1, and no flushed/incoming pc ever appears.
- Assert rst_n=0 mid-stream (asynchronously) -> out_valid falls immediately, outputs 0. Re-release -> first new instruction appears 1 cycle after acceptance.
